// File: rtl/coco_pkg.sv
// Shared types and constants for the COCO timer/counter register front end.
package coco_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [1:0] AddrCtrl     = 2'd0;
  localparam logic [1:0] AddrPreset   = 2'd1;
  localparam logic [1:0] AddrCount    = 2'd2;
  localparam logic [1:0] AddrUnmapped = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/coco_arbiter.sv
// Serialises two requesters onto one COCO register interface and routes the
// timer interrupt to whichever requester last wrote the control register.
module coco_arbiter
  import coco_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [3:2]           addr0,
  input  logic [3:2]           addr1,
  input  logic [DataWidth-1:0] wdata0,
  input  logic [DataWidth-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DataWidth-1:0] rdata0,
  output logic [DataWidth-1:0] rdata1,
  output logic [3:2]           dev_addr,
  output logic                 dev_we,
  output logic [DataWidth-1:0] dev_wdata,
  input  logic [DataWidth-1:0] dev_rdata,
  input  logic                 dev_irq,
  output logic                 irq0,
  output logic                 irq1
);

  state_e               state_q, state_d;
  logic                 win_q;
  logic                 we_q;
  logic [1:0]           addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 last_grant_q;
  logic                 owner_q;
  logic                 owner_valid_q;
  logic [DataWidth-1:0] rdata0_q, rdata1_q;

  logic                 grant;
  logic                 grant_en;
  logic [DataWidth-1:0] rd_cap;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign grant_en = (state_q == StIdle) && (req0 || req1);
  assign rd_cap   = (addr_q == AddrUnmapped) ? '0 : dev_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        win_q        <= grant;
        we_q         <= grant ? we1 : we0;
        addr_q       <= grant ? addr1 : addr0;
        wdata_q      <= grant ? wdata1 : wdata0;
        last_grant_q <= grant;
      end
      if (state_q == StAccess) begin
        if (!we_q) begin
          if (win_q) rdata1_q <= rd_cap;
          else       rdata0_q <= rd_cap;
        end else if (addr_q == AddrCtrl) begin
          owner_q       <= win_q;
          owner_valid_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dev_addr  = '0;
    dev_wdata = '0;
    dev_we    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_en) state_d = StAccess;
      end
      StAccess: begin
        dev_addr  = addr_q;
        dev_wdata = wdata_q;
        dev_we    = we_q && (addr_q != AddrUnmapped);
        state_d   = StResp;
      end
      StResp: begin
        ack0    = ~win_q;
        ack1    = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign irq0   = dev_irq & owner_valid_q & ~owner_q;
  assign irq1   = dev_irq & owner_valid_q & owner_q;

endmodule

// File: tb/tb_coco_arbiter.sv
// Directed bench for coco_arbiter: table of single transactions plus
// hand-written reset-abort and back-to-back tie sequences.
module tb_coco_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [3:2]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [3:2]  dev_addr;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        dev_irq;
  logic        irq0, irq1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coco_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_irq   (dev_irq),
    .irq0      (irq0),
    .irq1      (irq1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dev_rd;
    int          exp_pulses;
    logic [31:0] exp_rdata;
    logic        exp_irq0;
    logic        exp_irq1;
  } vec_t;

  vec_t vecs[7];

  // Per-transaction observations
  int          ack_cyc, pulses, pulse_cyc;
  logic [1:0]  seen_addr;
  logic [31:0] seen_wdata, seen_rdata;

  task automatic run_txn(input vec_t v);
    ack_cyc = 0; pulses = 0; pulse_cyc = 0;
    seen_addr = 2'b00; seen_wdata = '0; seen_rdata = '0;
    @(posedge clk); #1;
    dev_rdata = v.dev_rd;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (dev_we) begin
        pulses++; pulse_cyc = c; seen_addr = dev_addr; seen_wdata = dev_wdata;
      end
      if (ack0 || ack1) begin
        ack_cyc = c;
        check("ack_port", {31'd0, ack1}, {31'd0, v.port});
        check("ack_both", {31'd0, ack0 & ack1}, 32'd0);
        seen_rdata = v.port ? rdata1 : rdata0;
        req0 = 1'b0; req1 = 1'b0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; dev_rdata = 0; dev_irq = 1'b1;

    // port, we, addr, wdata, dev_rdata, pulses, rdata, irq0, irq1
    vecs[0] = '{1'b0, 1'b1, 2'd1, 32'd5,        32'h0,        1, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 32'd9,        32'h0,        1, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h3,        0, 32'h3,        1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h1,        32'h0,        1, 32'h0,        1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 2'd3, 32'h0,        32'hDEADBEEF, 0, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h12345678, 0, 32'h12345678, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_dev_we", {31'd0, dev_we}, 32'd0);
    check("rst_dev_addr", {30'd0, dev_addr}, 32'd0);
    check("rst_dev_wdata", dev_wdata, 32'd0);
    check("rst_irq0", {31'd0, irq0}, 32'd0);
    check("rst_irq1", {31'd0, irq1}, 32'd0);
    dev_irq = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i]);
      // Raised in IDLE: negedges fall in IDLE, ACCESS, then the ack cycle
      check($sformatf("v%0d_ack_cyc", i), ack_cyc, 32'd3);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses == 1) begin
        check($sformatf("v%0d_pulse_cyc", i), pulse_cyc, 32'd2);
        check($sformatf("v%0d_dev_addr", i), {30'd0, seen_addr}, {30'd0, vecs[i].addr});
        check($sformatf("v%0d_dev_wdata", i), seen_wdata, vecs[i].wdata);
      end
      if (!vecs[i].we)
        check($sformatf("v%0d_rdata", i), seen_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_irq0_lo", i), {31'd0, irq0}, 32'd0);
      check($sformatf("v%0d_irq1_lo", i), {31'd0, irq1}, 32'd0);
      dev_irq = 1'b1; #1;
      check($sformatf("v%0d_irq0", i), {31'd0, irq0}, {31'd0, vecs[i].exp_irq0});
      check($sformatf("v%0d_irq1", i), {31'd0, irq1}, {31'd0, vecs[i].exp_irq1});
      dev_irq = 1'b0;
    end
    check("rdata1_held", rdata1, 32'h3);

    // Reset lands while a ctrl write is in ACCESS
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 32'h7;
    @(posedge clk); #1;
    check("abort_in_access", {31'd0, dev_we}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; dev_irq = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1 || dev_we) pulses++;
    end
    check("abort_no_ack_we", pulses, 32'd0);
    check("abort_irq0", {31'd0, irq0}, 32'd0);
    check("abort_irq1", {31'd0, irq1}, 32'd0);
    dev_irq = 1'b0;

    // Both held high: reset left last_grant = 1, so port 0 takes the first tie
    @(posedge clk); #1;
    dev_rdata = 32'hA5;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
    begin
      int n;
      n = 0;
      for (int c = 1; c <= 20 && n < 4; c++) begin
        @(negedge clk);
        if (dev_we) check("tie_dev_we", 32'd1, 32'd0);
        if (ack0 || ack1) begin
          check($sformatf("tie%0d_both", n), {31'd0, ack0 & ack1}, 32'd0);
          check($sformatf("tie%0d_port", n), {31'd0, ack1}, n % 2);
          check($sformatf("tie%0d_cyc", n), c, 3 + 3 * n);
          n++;
        end
      end
      check("tie_count", n, 32'd4);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_rdata0", rdata0, 32'hA5);
    check("tie_rdata1", rdata1, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
